// File: rtl/scalar_mult_ctrl.sv
// ----------------------------------------------------------------------------
// scalar_mult_ctrl
//
// Purpose:
//   Sequences the shared point ALU to compute Q = k*P on Ed25519 in projective
//   {X,Y,Z} coordinates using MSB-first double-and-add, then issues a final
//   reduce op so the returned point is affine {x,y,1}.
//
// Build option:
//   SCALAR_MULT_CONST_TIME_EN - when defined, an add is issued after every
//   double and its result is kept only for 1-bits, so the op sequence and the
//   latency do not depend on k. When undefined, adds are skipped for 0-bits.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           start pulse, honoured only when idle
//   i_scalar          scalar k (NBITS), captured on accepted start
//   i_point           base point P {X,Y,Z} (3*CW), captured on accepted start
//   o_busy            high from accepted start through the o_valid cycle
//   o_valid           one-cycle pulse, o_point holds the new result
//   o_point           affine result {x,y,1}, held until the next start
//   o_alu_ivalid      one-cycle op request to the point ALU
//   o_alu_op          00 double, 01 add, 11 reduce
//   o_alu_point1      operand 1 (accumulator R)
//   o_alu_point2      operand 2 (P for add, zero otherwise)
//   i_alu_ovalid      ALU result pulse
//   i_alu_opoint      ALU result point
// ----------------------------------------------------------------------------
module scalar_mult_ctrl #(
    parameter int NBITS = 255,
    parameter int CW    = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NBITS-1:0]    i_scalar,
    input  logic [3*CW-1:0]     i_point,
    output logic                o_busy,
    output logic                o_valid,
    output logic [3*CW-1:0]     o_point,
    output logic                o_alu_ivalid,
    output logic [1:0]          o_alu_op,
    output logic [3*CW-1:0]     o_alu_point1,
    output logic [3*CW-1:0]     o_alu_point2,
    input  logic                i_alu_ovalid,
    input  logic [3*CW-1:0]     i_alu_opoint
);

    localparam int PW = 3 * CW;
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [1:0] OP_DBL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_RED = 2'b11;

    localparam logic [CW-1:0] CW_ONE   = CW'(1);
    localparam logic [PW-1:0] IDENTITY = {{CW{1'b0}}, CW_ONE, CW_ONE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DBL_ISSUE,
        S_DBL_WAIT,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_NEXT,
        S_RED_ISSUE,
        S_RED_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     r_q, r_d;
    logic [PW-1:0]     p_q, p_d;
    logic [NBITS-1:0]  k_q, k_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [PW-1:0]     opoint_q, opoint_d;
    logic              ivalid_q, ivalid_d;
    logic [1:0]        op_q, op_d;
    logic [PW-1:0]     p1_q, p1_d;
    logic [PW-1:0]     p2_q, p2_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            p_q      <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            opoint_q <= '0;
            ivalid_q <= 1'b0;
            op_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            p_q      <= p_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            opoint_q <= opoint_d;
            ivalid_q <= ivalid_d;
            op_q     <= op_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

    // ALU request signals are registered: the ISSUE state loads them, so the
    // request pulse is seen by the ALU during the first WAIT cycle and the op
    // and operands stay put until the next ISSUE state.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        p_d      = p_q;
        k_d      = k_q;
        idx_d    = idx_q;
        busy_d   = valid_q ? 1'b0 : busy_q;
        valid_d  = 1'b0;
        opoint_d = opoint_q;
        ivalid_d = 1'b0;
        op_d     = op_q;
        p1_d     = p1_q;
        p2_d     = p2_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_d     = i_scalar;
                    p_d     = i_point;
                    r_d     = IDENTITY;
                    idx_d   = IW'(NBITS - 1);
                    busy_d  = 1'b1;
                    state_d = S_DBL_ISSUE;
                end
            end
            S_DBL_ISSUE: begin
                ivalid_d = 1'b1;
                op_d     = OP_DBL;
                p1_d     = r_q;
                p2_d     = '0;
                state_d  = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (i_alu_ovalid) begin
                    r_d = i_alu_opoint;
`ifdef SCALAR_MULT_CONST_TIME_EN
                    state_d = S_ADD_ISSUE;
`else
                    state_d = k_q[NBITS-1] ? S_ADD_ISSUE : S_NEXT;
`endif
                end
            end
            S_ADD_ISSUE: begin
                ivalid_d = 1'b1;
                op_d     = OP_ADD;
                p1_d     = r_q;
                p2_d     = p_q;
                state_d  = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (i_alu_ovalid) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    // Dummy add for a 0-bit: the result is dropped.
                    if (k_q[NBITS-1]) begin
                        r_d = i_alu_opoint;
                    end
`else
                    r_d = i_alu_opoint;
`endif
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                k_d = k_q << 1;
                if (idx_q == '0) begin
                    state_d = S_RED_ISSUE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_DBL_ISSUE;
                end
            end
            S_RED_ISSUE: begin
                ivalid_d = 1'b1;
                op_d     = OP_RED;
                p1_d     = r_q;
                p2_d     = '0;
                state_d  = S_RED_WAIT;
            end
            S_RED_WAIT: begin
                if (i_alu_ovalid) begin
                    opoint_d = i_alu_opoint;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
    assign o_point      = opoint_q;
    assign o_alu_ivalid = ivalid_q;
    assign o_alu_op     = op_q;
    assign o_alu_point1 = p1_q;
    assign o_alu_point2 = p2_q;

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Sequencer that computes Q = k·P on Ed25519 in projective {X,Y,Z} coordinates, then returns the affine result.
- Drives the shared point ALU (double / add / reduce ops, single-op-in-flight handshake) using MSB-first double-and-add over a fixed number of scalar bits.
- Sits between the signature top-level (which supplies scalar and base point) and the point ALU.

Parameters:
- NBITS, 255, scalar bits processed (MSB first).
- CW, 255, coordinate width; point width is 3*CW.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_scalar  in  NBITS  scalar k, captured on accepted start
- i_point  in  3*CW  base point P {X,Y,Z}, captured on accepted start
- o_busy  out  1  high from accepted start until o_valid cycle inclusive
- o_valid  out  1  one-cycle pulse, result ready
- o_point  out  3*CW  affine result {x,y,1}, held until next accepted start
- o_alu_ivalid  out  1  one-cycle op request to ALU
- o_alu_op  out  2  00 double, 01 add, 11 reduce
- o_alu_point1  out  3*CW  operand 1 (accumulator R)
- o_alu_point2  out  3*CW  operand 2 (P for add, zero otherwise)
- i_alu_ovalid  in  1  ALU result pulse
- i_alu_opoint  in  3*CW  ALU result

Behaviour:
- Reset: all outputs 0; state IDLE; R, P, k registers cleared.
- Registers:
  - R (accumulator), P (base), k (scalar shift register).
  - bit counter idx, width clog2(NBITS), counts NBITS-1 down to 0.
- States:
  - IDLE: on i_start, capture k and P, set R = identity {0,1,1}, idx = NBITS-1, go DBL_ISSUE. Otherwise stay.
  - DBL_ISSUE: assert o_alu_ivalid for exactly one cycle with op 00, point1 = R, point2 = 0; go DBL_WAIT.
  - DBL_WAIT: on i_alu_ovalid, R <= i_alu_opoint. Go ADD_ISSUE if k[NBITS-1] = 1, else NEXT.
  - ADD_ISSUE: one-cycle request, op 01, point1 = R, point2 = P; go ADD_WAIT.
  - ADD_WAIT: on i_alu_ovalid, R <= i_alu_opoint; go NEXT.
  - NEXT: shift k left by 1. If idx == 0 go RED_ISSUE, else idx-- and go DBL_ISSUE.
  - RED_ISSUE: op 11, point1 = R; go RED_WAIT.
  - RED_WAIT: on i_alu_ovalid, o_point <= i_alu_opoint, pulse o_valid next cycle; go IDLE.
- Handshake:
  - Never more than one op outstanding.
  - Next request is issued no earlier than the cycle after i_alu_ovalid, so the ALU has returned to idle.
  - o_alu_op and operand outputs are registered and stable from the request cycle until i_alu_ovalid.
- Op count without the optional feature: NBITS doubles + popcount(k) adds + 1 reduce.
- i_alu_ovalid outside a WAIT state is ignored.
- i_start while busy is ignored and does not alter captured k or P.
- k = 0: all doubles act on identity; result {0,1,1}.
- Reset mid-operation: immediate return to IDLE, o_alu_ivalid = 0, o_valid never pulsed. The ALU shares i_rst, so no stale result arrives.
- Back-to-back: i_start in the cycle after o_valid is accepted.

Optional Feature:
- Macro SCALAR_MULT_CONST_TIME_EN.
- Defined:
  - ADD_ISSUE is always executed after every double.
  - In ADD_WAIT, R <= i_alu_opoint only if the current k bit is 1; otherwise R is unchanged and the result is discarded.
  - Op sequence and total latency are independent of k: exactly NBITS doubles + NBITS adds + 1 reduce.
- Undefined: adds are skipped for zero bits, as described above.

Test Plan:
- k=1, P=base point B, behavioural ALU model → o_point = affine B, i.e. {Bx, By, 1}; op trace is 255×00, one 01 at the final bit, then 11.
- k=0 → o_point = {0,1,1}; 255 doubles, 0 adds, 1 reduce; o_valid asserted exactly once.
- k=2 and k=8 → o_point equals the golden model for 2B and 8B; add count equals popcount(k).
- i_start pulsed mid-run with a different k → ignored; result matches the original k; o_busy stays high throughout.
- i_rst asserted during the 100th DBL_WAIT → next cycle state IDLE, o_busy=0, o_valid=0; a fresh start with k=3 then completes correctly.
- With SCALAR_MULT_CONST_TIME_EN: k=0, k=1 and k=2^254+1 each produce 511 ALU requests and identical cycle counts start→o_valid (fixed-latency ALU model), and results match the golden model.
